// File: rtl/mips_reg_file.sv
// mips_reg_file: general-purpose register file of the multi-cycle MIPS datapath
//
// Two combinational read ports (rs/rt) feed the A/B operand latch, one
// synchronous write port is driven by write-back, plus a side-effect-free
// debug read port. Register $0 is hardwired to zero.
//
// Ports:
//   clk        system clock, writes on rising edge
//   rst_n      asynchronous active-low reset, clears every register
//   rs_addr    read port A address      -> rdata_a
//   rt_addr    read port B address      -> rdata_b
//   wr_addr    write address
//   wr_data    write data
//   reg_write  write enable
//   dbg_addr   debug read address       -> dbg_data
//
// Optional build macro: MIPS_REG_FILE_WRITE_BYPASS_EN
//   When defined, rdata_a/rdata_b forward wr_data in the same cycle when
//   their address matches an enabled, non-$0 write. dbg_data never bypasses.
module mips_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_en;

    // $0 is never written, so it stays at its reset value of zero
    assign wr_en = reg_write && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    logic [DATA_W-1:0] arr_a, arr_b;

    // Gating with rst_n keeps outputs at zero for the whole reset interval
    assign arr_a    = (!rst_n || rs_addr == '0) ? '0 : regs[rs_addr];
    assign arr_b    = (!rst_n || rt_addr == '0) ? '0 : regs[rt_addr];
    assign dbg_data = (!rst_n || dbg_addr == '0) ? '0 : regs[dbg_addr];

`ifdef MIPS_REG_FILE_WRITE_BYPASS_EN
    // wr_en already excludes $0, so a $0 read can never pick up wr_data
    assign rdata_a = (rst_n && wr_en && rs_addr == wr_addr) ? wr_data : arr_a;
    assign rdata_b = (rst_n && wr_en && rt_addr == wr_addr) ? wr_data : arr_b;
`else
    assign rdata_a = arr_a;
    assign rdata_b = arr_b;
`endif

endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: directed self-checking bench for mips_reg_file
module tb_mips_reg_file;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [4:0]  rs_addr = 0, rt_addr = 0, wr_addr = 0, dbg_addr = 0;
    logic [31:0] wr_data = 0;
    logic        reg_write = 0;
    logic [31:0] rdata_a, rdata_b, dbg_data;
    int          n_run = 0, n_fail = 0;

    mips_reg_file dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .wr_addr(wr_addr), .wr_data(wr_data), .reg_write(reg_write),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_addr = a;
        wr_data = d;
        reg_write = 1;
        @(posedge clk);
        #1 reg_write = 0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] g);
        rs_addr = a;
        rt_addr = b;
        dbg_addr = g;
        #1;
    endtask

    initial begin
        rd(1, 17, 31);
        check("reset_a", rdata_a, 0);
        check("reset_b", rdata_b, 0);
        check("reset_dbg", dbg_data, 0);
        @(negedge clk) rst_n = 1;

        // basic write/read on consecutive cycles
        wr(8, 32'hDEADBEEF);
        wr(31, 32'h00000005);
        rd(8, 31, 8);
        check("basic_a", rdata_a, 32'hDEADBEEF);
        check("basic_b", rdata_b, 32'h00000005);
        check("basic_dbg", dbg_data, 32'hDEADBEEF);
        rd(31, 31, 31);
        check("same_addr_a", rdata_a, 32'h00000005);
        check("same_addr_b", rdata_b, 32'h00000005);

        // $0 protection, before and after the edge
        @(negedge clk);
        wr_addr = 0; wr_data = 32'hFFFFFFFF; reg_write = 1;
        rd(0, 0, 0);
        check("zero_pre", rdata_a, 0);
        @(posedge clk);
        #1 reg_write = 0;
        rd(0, 0, 0);
        check("zero_post_a", rdata_a, 0);
        check("zero_post_dbg", dbg_data, 0);

        // write enable low for three cycles
        @(negedge clk);
        wr_addr = 9; wr_data = 32'h12345678; reg_write = 0;
        repeat (3) @(posedge clk);
        rd(9, 9, 9);
        check("we_low_a", rdata_a, 0);
        check("we_low_dbg", dbg_data, 0);

        // same-cycle read/write on $12
        wr(12, 32'h11111111);
        @(negedge clk);
        wr_addr = 12; wr_data = 32'h22222222; reg_write = 1;
        rd(12, 12, 12);
`ifdef MIPS_REG_FILE_WRITE_BYPASS_EN
        check("rw_pre_a", rdata_a, 32'h22222222);
        check("rw_pre_b", rdata_b, 32'h22222222);
`else
        check("rw_pre_a", rdata_a, 32'h11111111);
        check("rw_pre_b", rdata_b, 32'h11111111);
`endif
        check("rw_pre_dbg", dbg_data, 32'h11111111);
        @(posedge clk);
        #1 reg_write = 0;
        check("rw_post_a", rdata_a, 32'h22222222);
        check("rw_post_dbg", dbg_data, 32'h22222222);

        // asynchronous reset pulse between edges clears preloaded registers
        wr(1, 32'h00000001);
        wr(17, 32'h00000017);
        rd(1, 17, 31);
        check("preload_a", rdata_a, 32'h00000001);
        check("preload_b", rdata_b, 32'h00000017);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check("async_rst_a", rdata_a, 0);
        check("async_rst_b", rdata_b, 0);
        check("async_rst_dbg", dbg_data, 0);
        #1 rst_n = 1;
        #1;
        rd(8, 12, 31);
        check("after_rst_a", rdata_a, 0);
        check("after_rst_b", rdata_b, 0);
        check("after_rst_dbg", dbg_data, 0);

        // reset held across a write edge: the write is lost
        @(negedge clk);
        wr_addr = 4; wr_data = 32'hA5A5A5A5; reg_write = 1;
        #2 rst_n = 0;
        @(posedge clk);
        #2 rst_n = 1;
        reg_write = 0;
        rd(4, 4, 4);
        check("mid_rst_a", rdata_a, 0);
        check("mid_rst_dbg", dbg_data, 0);

        // writes resume normally after reset release
        wr(4, 32'hA5A5A5A5);
        rd(4, 0, 4);
        check("resume_a", rdata_a, 32'hA5A5A5A5);
        check("resume_b", rdata_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- General-purpose register file of the multi-cycle MIPS datapath. Sits directly upstream of the A/B operand latch stage.
- Two asynchronous read ports (rs, rt) feed the latch inputs. The latch captures them on the next clk rising edge.
- One synchronous write port is driven by the write-back step (ALUOut or MDR result).
- Register $0 is hardwired to zero.

Parameters:
DATA_W, 32, width of each register and of the read/write data ports
ADDR_W, 5, register address width; the file holds 2**ADDR_W registers (32)

Ports:
clk  input  1  system clock, all writes on rising edge
rst_n  input  1  asynchronous active-low reset
rs_addr  input  ADDR_W  read port A address (instr[25:21])
rt_addr  input  ADDR_W  read port B address (instr[20:16])
wr_addr  input  ADDR_W  write address (rt or rd, selected upstream by RegDst)
wr_data  input  DATA_W  write data (selected upstream by MemtoReg)
reg_write  input  1  write enable, sampled on clk rising edge
rdata_a  output  DATA_W  read data A, to operand latch input a
rdata_b  output  DATA_W  read data B, to operand latch input b
dbg_addr  input  ADDR_W  debug/observation read address
dbg_data  output  DATA_W  debug read data for dbg_addr

Behaviour:
- Reset:
  - rst_n low asynchronously clears all 2**ADDR_W registers to 0, regardless of clk.
  - While rst_n is low, writes are ignored, and rdata_a, rdata_b and dbg_data read 0.
  - Reset asserted mid-cycle while reg_write=1: no write occurs and the file clears.
  - Release of rst_n takes effect on the next clk edge. No write happens on the release edge unless rst_n is already high at that edge.
- Write:
  - On clk rising edge with rst_n=1, reg_write=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - wr_addr==0: the write is discarded, and reg[0] stays 0 permanently.
  - reg_write=0: no register changes.
  - One write per cycle, with no latency beyond the edge. The written value is visible on the read ports after the edge.
- Read:
  - rdata_a = reg[rs_addr] and rdata_b = reg[rt_addr], combinational with zero-cycle latency.
  - An address of 0 always returns 0.
  - rs_addr==rt_addr is legal; both ports return the same value.
  - dbg_data = reg[dbg_addr], combinational, with the same $0 rule. The debug port has no side effects.
- Read/write same cycle, same address (default build): reads return the OLD value until the edge and the new value afterwards. This is correct for the multi-cycle flow, where write-back and decode never overlap on the same register in one cycle.
- Widths: all data paths are DATA_W bits with no sign handling. Addresses are full ADDR_W, so no out-of-range case exists.
- No X propagation: after reset every register is defined. Outputs must never be X once rst_n has been asserted once.

Optional Feature:
Macro: MIPS_REG_FILE_WRITE_BYPASS_EN
- Defined: write-through bypass on each read port. If reg_write=1, rst_n=1 and wr_addr!=0:
  - rdata_a returns wr_data combinationally when rs_addr==wr_addr.
  - rdata_b returns wr_data combinationally when rt_addr==wr_addr.
  - This makes the same-cycle value available to the downstream latch before the edge.
  - dbg_data is never bypassed.
  - wr_addr==0 never bypasses, so reads of $0 stay 0.
- Undefined: no bypass, with the same-cycle behaviour exactly as stated in Behaviour.

Test Plan:
- Reset clears everything: preload by writes, pulse rst_n low between clk edges -> rdata_a, rdata_b and dbg_data read 0 immediately, with no clk edge needed, for addresses 1, 17 and 31.
- Basic write/read: write 0xDEADBEEF to $8 and 0x00000005 to $31 on consecutive cycles. Then rs_addr=8, rt_addr=31 -> rdata_a=0xDEADBEEF, rdata_b=0x00000005.
- $0 protection: reg_write=1, wr_addr=0, wr_data=0xFFFFFFFF -> rdata_a with rs_addr=0 is 0x00000000. Under the bypass macro it is also 0 in the same cycle.
- Write enable low: reg_write=0, wr_addr=9, wr_data=0x12345678 for 3 cycles -> $9 still holds its prior value 0x00000000.
- Same-cycle read/write to $12 (old value 0x11111111, new 0x22222222):
  - Without macro: rdata_a=0x11111111 before the edge and 0x22222222 after it.
  - With macro: 0x22222222 before the edge.
  - dbg_data=0x11111111 before the edge in both builds.
- Reset mid-operation: reg_write=1, wr_addr=4, wr_data=0xA5A5A5A5, with rst_n dropped before the edge and released after it -> $4 reads 0x00000000.
